ex_muldiv: RTL
==============

# ex_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the EX stage of the 5-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register and consumes that register's operand and opcode outputs; `funct` is the low 6 bits of the sign-extend output. It executes MULT/MULTU/DIV/DIVU over multiple cycles, serves MFHI/MFLO/MTHI/MTLO, and raises `stall` to freeze IF/ID/EX whenever a HI/LO-class instruction arrives while an operation is in flight.

## Interface
- No parameters. Data width is fixed at 32 bits; HI/LO are 32 bits each.
- `clock` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `issue` in 1: the instruction at the ID/EX output is valid, not a bubble.
- `op_code` in 6: from ID/EX `op_code_out`.
- `funct` in 6: ID/EX `sign_extend_out[5:0]`.
- `data_a` in 32: rs value (dividend / multiplicand / MT source).
- `data_b` in 32: rt value (divisor / multiplier).
- `stall` out 1: combinational; hold the pipeline this cycle.
- `mf_result` out 32: combinational HI or LO value for MFHI/MFLO.
- `busy` out 1: registered; state is not IDLE.
- `hi_out` out 32: registered HI.
- `lo_out` out 32: registered LO.

## Operation
- Decode applies only when `op_code`==0 and `issue`==1. Funct codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other instruction is ignored and never stalled.
- `stall` = `issue` & HI/LO-class op & (state != IDLE). Non-HI/LO instructions overlap with a running operation.
- States:
  - IDLE: an accepted MULT*/DIV* latches operands and the signedness, clears the counter and moves to CALC.
  - CALC: 32 iterations, one per cycle, on the counter's 5-bit wrap. 31→0 moves to FIX.
  - FIX: applies sign correction, writes HI/LO and returns to IDLE.
- Signed ops run on magnitudes. FIX negates the results: the product if the operand signs differ, the quotient if the signs differ, the remainder if the dividend is negative.
- Multiply is shift-add with a 33-bit adder. HI:LO is the full 64-bit product.
- Divide is restoring with a 33-bit subtract. LO is the quotient and HI the remainder.
- Divide by zero (both signednesses): LO=0xFFFFFFFF, HI=data_a. Completes in normal time.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO in IDLE: write `data_a` to HI/LO at the edge. Any in-flight result is never clobbered because these ops stall when busy.
- MFHI/MFLO in IDLE: `mf_result` is the current HI/LO. Otherwise `mf_result` is 0.
- Reset, including mid-operation: state IDLE, HI=LO=0, counter 0, operand registers 0, `busy`=0, `stall`=0 from the next cycle.

## Timing
- The accept edge is E. `busy` is high from E to E+33, and HI/LO update at edge E+33.
- A dependent MFHI/MFLO presented right after the MULT/DIV sees `stall` high for 33 cycles and reads the new value on the 34th.
- An issue of a HI/LO-class op during FIX stalls. It is accepted on the first IDLE cycle, so there is no back-to-back issue without one IDLE cycle.
- MTHI/MTLO latency is 1 edge. MF reads are 0-cycle combinational.

## Structure
- Shared definitions in `pipeline_defs`: funct constants, the SPECIAL opcode, and the state encoding (IDLE/CALC/FIX).
- One sub-module, `muldiv_core`, holds the iterative engine: counter, 64-bit working register, 33-bit add/sub, FIX sign logic, start/done.
- `ex_muldiv` keeps decode, stall, the HI/LO registers and MT/MF handling.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → at E+33: HI=0xFFFFFFFE, LO=0x00000001. `busy` is high for exactly 33 cycles.
- MULT −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- MULT 6×7 followed by MFLO held on the ID/EX output → `stall` high 33 cycles. Then `mf_result`=42 with `stall` low. An interleaved ADD (op 0, funct 0x20) is never stalled.
- MTHI 0x1234, then MFHI next cycle → `mf_result`=0x1234. MTLO while busy → stalls, and LO is written only after the op's result lands.
- Reset asserted at cycle 10 of a DIVU → next cycle `busy`=0, HI=LO=0, and a fresh MULTU 2×3 gives LO=6.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared decode constants and multiply/divide engine state encoding for the EX stage.
// Both the HI/LO wrapper and the iterative core import this package.
package pipeline_defs;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_hilo_op(input logic [5:0] fn);
    return fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  function automatic logic is_muldiv_op(input logic [5:0] fn);
    return fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  // Magnitude of a value that is two's complement only when signed_en is set.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic signed_en);
    return (signed_en && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side connection of the multiply/divide unit: decoded instruction in,
// stall / move-from data and architectural HI/LO visibility out.
interface ex_muldiv_if;

  logic        issue;
  logic [5:0]  op_code;
  logic [5:0]  funct;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        stall;
  logic [31:0] mf_result;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output issue, op_code, funct, data_a, data_b,
    input  stall, mf_result, busy, hi_out, lo_out
  );

  modport slave (
    input  issue, op_code, funct, data_a, data_b,
    output stall, mf_result, busy, hi_out, lo_out
  );

endinterface

// File: rtl/ex_muldiv_core.sv
// Iterative 32-bit multiply (shift-add) / divide (restoring) engine.
// Runs on operand magnitudes for 32 CALC cycles, then one FIX cycle applies signs.
module muldiv_core
  import pipeline_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_div,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  md_state_e   state;
  logic [4:0]  count;
  logic [63:0] work;       // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] operand;    // mul: multiplicand magnitude; div: divisor magnitude
  logic        div_op;
  logic        neg_main;   // negate product or quotient
  logic        neg_rem;
  logic        div_zero;

  logic [32:0] add_sum;
  logic [32:0] rem_shift;
  logic [32:0] sub_diff;
  logic [63:0] work_next;

  always_comb begin
    // NOTE: every output of this block is assigned before any branch, so no latch can be inferred.
    add_sum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand} : 33'd0);
    rem_shift = {work[63:32], work[31]};
    sub_diff  = rem_shift - {1'b0, operand};
    work_next = {add_sum, work[31:1]};
    if (div_op) begin
      // Bit 32 of the difference is the borrow: restore on borrow, quotient bit 0.
      work_next = sub_diff[32] ? {rem_shift[31:0], work[30:0], 1'b0}
                               : {sub_diff[31:0],  work[30:0], 1'b1};
    end
  end

  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  always_comb begin
    prod_fixed = neg_main ? -work : work;
    quo_fixed  = neg_main ? -work[31:0] : work[31:0];
    rem_fixed  = neg_rem  ? -work[63:32] : work[63:32];
    // With a zero divisor the remainder path just shifts the dividend through,
    // so only the quotient needs forcing.
    if (div_zero) quo_fixed = 32'hFFFF_FFFF;
    hi_res = div_op ? rem_fixed : prod_fixed[63:32];
    lo_res = div_op ? quo_fixed : prod_fixed[31:0];
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= ST_IDLE;
      count    <= 5'd0;
      work     <= 64'd0;
      operand  <= 32'd0;
      div_op   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_CALC;
            busy     <= 1'b1;
            count    <= 5'd0;
            div_op   <= is_div;
            neg_main <= is_signed && (a[31] ^ b[31]);
            neg_rem  <= is_signed && is_div && a[31];
            div_zero <= is_div && (b == 32'd0);
            work     <= {32'd0, is_div ? abs32(a, is_signed) : abs32(b, is_signed)};
            operand  <= is_div ? abs32(b, is_signed) : abs32(a, is_signed);
          end
        end
        ST_CALC: begin
          work  <= work_next;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state <= ST_FIX;
            done  <= 1'b1;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: instruction decode, pipeline stall, HI/LO
// registers and MFHI/MFLO/MTHI/MTLO around the iterative muldiv_core.
module ex_muldiv
  import pipeline_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  ex_muldiv_if.slave bus
);

  logic        special;
  logic        hilo_op;
  logic        start;
  logic        core_busy;
  logic        core_done;
  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  assign special = bus.issue && (bus.op_code == OP_SPECIAL);
  assign hilo_op = special && is_hilo_op(bus.funct);
  assign start   = hilo_op && !core_busy && is_muldiv_op(bus.funct);

  // Only HI/LO-class ops wait on the engine; everything else overlaps with it.
  assign bus.stall = hilo_op && core_busy;

  // funct[1] selects divide, funct[0] selects the unsigned variant.
  muldiv_core u_core (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_div    (bus.funct[1]),
    .is_signed (~bus.funct[0]),
    .a         (bus.data_a),
    .b         (bus.data_b),
    .busy      (core_busy),
    .done      (core_done),
    .hi_res    (hi_res),
    .lo_res    (lo_res)
  );

  // MT ops stall while the core is busy, so they can never collide with a result write.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (core_done) begin
      hi_q <= hi_res;
      lo_q <= lo_res;
    end else if (special && !core_busy) begin
      if (bus.funct == FN_MTHI) hi_q <= bus.data_a;
      if (bus.funct == FN_MTLO) lo_q <= bus.data_a;
    end
  end

  always_comb begin
    bus.mf_result = 32'd0;
    if (special && !core_busy) begin
      if (bus.funct == FN_MFHI) bus.mf_result = hi_q;
      else if (bus.funct == FN_MFLO) bus.mf_result = lo_q;
    end
  end

  assign bus.busy   = core_busy;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule
